// File: rtl/psram_pkg.sv
// Shared state encoding, page geometry and burst limits for the PSRAM write coalescer.
package psram_pkg;

   typedef enum logic [2:0] {
      IDLE,
      COLLECT,
      REQUEST,
      STREAM,
      WAIT_DONE
   } state_t;

   localparam int PAGE_SIZE       = 1024;
   localparam int PAGE_BITS       = $clog2(PAGE_SIZE);
   localparam int MAX_BURST_LIMIT = 32;

   // A burst may not run into the first byte of the next PSRAM page.
   function automatic logic is_page_start(input logic [PAGE_BITS-1:0] offset);
      return offset == '0;
   endfunction

endpackage

// File: rtl/psram_byte_fifo.sv
// Byte FIFO holding one burst worth of data; DEPTH need not be a power of two.
module psram_byte_fifo #(
   parameter  int DEPTH = 32,
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int LW    = $clog2(DEPTH + 1)
) (
   input  logic          sysclk,
   input  logic          reset,
   input  logic          i_push,
   input  logic [7:0]    i_data,
   input  logic          i_pop,
   output logic [7:0]    o_head,
   output logic          o_full,
   output logic          o_empty,
   output logic [LW-1:0] o_level
);

   logic [7:0]    r_mem [DEPTH];
   logic [AW-1:0] r_wr;
   logic [AW-1:0] r_rd;
   logic [LW-1:0] r_level;
   logic          w_push;
   logic          w_pop;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] ptr);
      return (ptr == AW'(DEPTH - 1)) ? '0 : ptr + AW'(1);
   endfunction

   assign w_push  = i_push && (r_level != LW'(DEPTH));
   assign w_pop   = i_pop && (r_level != '0);
   assign o_head  = r_mem[r_rd];
   assign o_full  = (r_level == LW'(DEPTH));
   assign o_empty = (r_level == '0);
   assign o_level = r_level;

   // NOTE: storage has no reset; only the pointers and level define what is valid.
   always_ff @(posedge sysclk) begin
      if (w_push) r_mem[r_wr] <= i_data;
   end

   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_level <= '0;
      end else begin
         if (w_push) r_wr <= ptr_inc(r_wr);
         if (w_pop)  r_rd <= ptr_inc(r_rd);
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + LW'(1);
            2'b01:   r_level <= r_level - LW'(1);
            default: r_level <= r_level;
         endcase
      end
   end

endmodule

// File: rtl/psram_write_coalescer.sv
// Merges contiguous host byte writes into page-bounded PSRAM bursts.
// Define PSRAM_COALESCER_STATS_EN to add the stat_bursts / stat_bytes counters.
module psram_write_coalescer
   import psram_pkg::*;
#(
   parameter int MAX_BURST    = 32,
   parameter int IDLE_TIMEOUT = 64
) (
   input  logic        sysclk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [23:0] in_address,
   input  logic [7:0]  in_data,
   input  logic        flush,
   output logic        burst_req,
   input  logic        burst_ack,
   output logic [23:0] burst_address,
   output logic [5:0]  burst_size,
   input  logic        next_byte_needed,
   output logic [7:0]  burst_data,
   input  logic        burst_done,
   output logic        busy
`ifdef PSRAM_COALESCER_STATS_EN
   ,
   output logic [15:0] stat_bursts,
   output logic [23:0] stat_bytes
`endif
);

   localparam int DEPTH = (MAX_BURST > MAX_BURST_LIMIT) ? MAX_BURST_LIMIT :
                          (MAX_BURST < 1) ? 1 : MAX_BURST;
   localparam int LW    = $clog2(DEPTH + 1);
   localparam int IW    = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;

   state_t        r_state;
   state_t        w_state_nxt;
   logic          r_rdy_en;
   logic [23:0]   r_addr;
   logic [5:0]    r_count;
   logic [IW-1:0] r_idle;
   logic [IW-1:0] w_idle_nxt;
   logic [7:0]    r_hold;
   logic          w_accept;
   logic          w_contig;
   logic          w_timeout;
   logic          w_pop;
   logic          w_full;
   logic          w_empty;
   logic [7:0]    w_head;
   logic [LW-1:0] w_level;

   psram_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
      .sysclk  (sysclk),
      .reset   (reset),
      .i_push  (w_accept),
      .i_data  (in_data),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_level (w_level)
   );

   assign w_contig  = (in_address == r_addr + 24'(r_count)) &&
                      !is_page_start(in_address[PAGE_BITS-1:0]);
   assign w_accept  = in_valid && in_ready;
   assign w_pop     = (r_state == STREAM) && next_byte_needed && !w_empty;
   assign w_timeout = (w_idle_nxt == IW'(IDLE_TIMEOUT));

   always_comb begin
      if (w_accept)                          w_idle_nxt = '0;
      else if (r_idle == IW'(IDLE_TIMEOUT))  w_idle_nxt = r_idle;
      else                                   w_idle_nxt = r_idle + IW'(1);
   end

   // NOTE: non-blocking assignments for every register so all flops update from pre-edge values.
   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   // NOTE: default assignment first so no path through the case leaves w_state_nxt unassigned (no latch).
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:      if (w_accept) w_state_nxt = COLLECT;
         COLLECT:   if (r_count == 6'(DEPTH) || flush || w_timeout || (in_valid && !w_contig))
                       w_state_nxt = REQUEST;
         REQUEST:   if (burst_ack) w_state_nxt = STREAM;
         STREAM:    if (w_pop && w_level == LW'(1)) w_state_nxt = WAIT_DONE;
         WAIT_DONE: if (burst_done) w_state_nxt = IDLE;
         default:   w_state_nxt = IDLE;
      endcase
   end

   // A rejected non-contiguous byte sees in_ready low in the same cycle it is offered.
   always_comb begin
      in_ready = 1'b0;
      case (r_state)
         IDLE:    in_ready = r_rdy_en && !w_full;
         COLLECT: in_ready = !w_full && (!in_valid || w_contig);
         default: in_ready = 1'b0;
      endcase
      burst_req     = (r_state == REQUEST);
      busy          = (r_state != IDLE) || !w_empty;
      burst_data    = w_empty ? r_hold : w_head;
      burst_address = r_addr;
      burst_size    = r_count;
   end

   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
         r_rdy_en <= 1'b0;
         r_addr   <= '0;
         r_count  <= '0;
         r_idle   <= '0;
         r_hold   <= '0;
      end else begin
         r_rdy_en <= 1'b1;
         r_idle   <= (r_state == COLLECT) ? w_idle_nxt : '0;
         if (w_accept) begin
            if (r_state == IDLE) begin
               r_addr  <= in_address;
               r_count <= 6'd1;
            end else begin
               r_count <= r_count + 6'd1;
            end
         end
         if (w_pop) r_hold <= w_head;
      end
   end

`ifdef PSRAM_COALESCER_STATS_EN
   logic [15:0] r_stat_bursts;
   logic [23:0] r_stat_bytes;

   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
         r_stat_bursts <= '0;
         r_stat_bytes  <= '0;
      end else begin
         if (r_state == REQUEST && burst_ack) r_stat_bursts <= r_stat_bursts + 16'd1;
         if (w_pop)                           r_stat_bytes  <= r_stat_bytes + 24'd1;
      end
   end

   assign stat_bursts = r_stat_bursts;
   assign stat_bytes  = r_stat_bytes;
`endif

endmodule

// File: tb/tb_psram_write_coalescer.sv
// Directed bench for psram_write_coalescer: full bursts, breaks, page crossing, timeout, flush, reset.
module tb_psram_write_coalescer;

   logic        sysclk = 1'b0;
   logic        reset = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [23:0] in_address = '0;
   logic [7:0]  in_data = '0;
   logic        flush = 1'b0;
   logic        burst_req;
   logic        burst_ack = 1'b0;
   logic [23:0] burst_address;
   logic [5:0]  burst_size;
   logic        next_byte_needed = 1'b0;
   logic [7:0]  burst_data;
   logic        burst_done = 1'b0;
   logic        busy;
`ifdef PSRAM_COALESCER_STATS_EN
   logic [15:0] stat_bursts;
   logic [23:0] stat_bytes;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   logic [23:0] cap_addr;
   logic [5:0]  cap_size;
   logic [7:0]  cap_data [32];
   int          cap_wait;
   bit          cap_to;
   bit          cap_rdy_hi;
   logic        cap_req_after_ack;

   psram_write_coalescer #(.MAX_BURST(32), .IDLE_TIMEOUT(64)) dut (
      .sysclk           (sysclk),
      .reset            (reset),
      .in_valid         (in_valid),
      .in_ready         (in_ready),
      .in_address       (in_address),
      .in_data          (in_data),
      .flush            (flush),
      .burst_req        (burst_req),
      .burst_ack        (burst_ack),
      .burst_address    (burst_address),
      .burst_size       (burst_size),
      .next_byte_needed (next_byte_needed),
      .burst_data       (burst_data),
      .burst_done       (burst_done),
      .busy             (busy)
`ifdef PSRAM_COALESCER_STATS_EN
      ,
      .stat_bursts      (stat_bursts),
      .stat_bytes       (stat_bytes)
`endif
   );

   always #5 sysclk = ~sysclk;

   task automatic tick();
      @(posedge sysclk);
      #1;
   endtask

   task automatic push_byte(input logic [23:0] a, input logic [7:0] d);
      int k = 0;
      in_valid = 1'b1;
      in_address = a;
      in_data = d;
      #1;
      while (!in_ready && k < 200) begin
         tick();
         k++;
      end
      if (!in_ready) begin
         n_checks++;
         n_fail++;
         $display("FAIL push_timeout addr=%h in_ready=%b required 1", a, in_ready);
      end else begin
         tick();
      end
      in_valid = 1'b0;
   endtask

   task automatic pulse_flush();
      flush = 1'b1;
      tick();
      flush = 1'b0;
   endtask

   // Controller model: waits for a request, acks, pulls size bytes, then signals done.
   task automatic serve_burst();
      int k = 0;
      cap_to = 1'b0;
      cap_rdy_hi = 1'b0;
      cap_addr = '0;
      cap_size = '0;
      cap_req_after_ack = 1'b0;
      for (int i = 0; i < 32; i++) cap_data[i] = '0;
      while (!burst_req && k < 200) begin
         tick();
         k++;
      end
      cap_wait = k;
      if (!burst_req) begin
         cap_to = 1'b1;
         return;
      end
      cap_addr = burst_address;
      cap_size = burst_size;
      if (in_ready) cap_rdy_hi = 1'b1;
      burst_ack = 1'b1;
      tick();
      burst_ack = 1'b0;
      cap_req_after_ack = burst_req;
      for (int i = 0; i < int'(cap_size) && i < 32; i++) begin
         next_byte_needed = 1'b1;
         #1;
         cap_data[i] = burst_data;
         if (in_ready) cap_rdy_hi = 1'b1;
         tick();
      end
      next_byte_needed = 1'b0;
      if (in_ready) cap_rdy_hi = 1'b1;
      burst_done = 1'b1;
      tick();
      burst_done = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(posedge sysclk);
      #1;
      n_checks++; if (in_ready !== 1'b0)       begin n_fail++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
      n_checks++; if (burst_req !== 1'b0)      begin n_fail++; $display("FAIL reset_burst_req got=%b exp=0", burst_req); end
      n_checks++; if (burst_address !== 24'h0) begin n_fail++; $display("FAIL reset_burst_address got=%h exp=0", burst_address); end
      n_checks++; if (burst_size !== 6'd0)     begin n_fail++; $display("FAIL reset_burst_size got=%0d exp=0", burst_size); end
      n_checks++; if (burst_data !== 8'h00)    begin n_fail++; $display("FAIL reset_burst_data got=%h exp=0", burst_data); end
      n_checks++; if (busy !== 1'b0)           begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
      reset = 1'b1;
      #1;
      n_checks++; if (in_ready !== 1'b0)       begin n_fail++; $display("FAIL release_in_ready_pre_clk got=%b exp=0", in_ready); end
      tick();
      n_checks++; if (in_ready !== 1'b1)       begin n_fail++; $display("FAIL release_in_ready_first_clk got=%b exp=1", in_ready); end
   endtask

   task automatic test_full_burst();
      int bad = 0;
      for (int i = 0; i < 32; i++) push_byte(24'h000100 + 24'(i), 8'(i + 1));
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready_33rd got=%b exp=0", in_ready); end
      n_checks++; if (busy !== 1'b1)     begin n_fail++; $display("FAIL full_busy got=%b exp=1", busy); end
      serve_burst();
      for (int i = 0; i < 32; i++) if (cap_data[i] !== 8'(i + 1)) bad++;
      n_checks++; if (cap_to !== 1'b0)             begin n_fail++; $display("FAIL full_req_timeout got=%b exp=0", cap_to); end
      n_checks++; if (cap_wait != 1)               begin n_fail++; $display("FAIL full_req_latency got=%0d exp=1", cap_wait); end
      n_checks++; if (cap_addr !== 24'h000100)     begin n_fail++; $display("FAIL full_addr got=%h exp=000100", cap_addr); end
      n_checks++; if (cap_size !== 6'd32)          begin n_fail++; $display("FAIL full_size got=%0d exp=32", cap_size); end
      n_checks++; if (bad != 0)                    begin n_fail++; $display("FAIL full_data bad_bytes=%0d exp=0", bad); end
      n_checks++; if (cap_req_after_ack !== 1'b0)  begin n_fail++; $display("FAIL full_req_drop got=%b exp=0", cap_req_after_ack); end
      n_checks++; if (cap_rdy_hi !== 1'b0)         begin n_fail++; $display("FAIL full_ready_during_burst got=%b exp=0", cap_rdy_hi); end
      n_checks++; if (in_ready !== 1'b1)           begin n_fail++; $display("FAIL full_ready_after_done got=%b exp=1", in_ready); end
      n_checks++; if (busy !== 1'b0)               begin n_fail++; $display("FAIL full_busy_after_done got=%b exp=0", busy); end
   endtask

   task automatic test_noncontig();
      push_byte(24'h000010, 8'hA0);
      push_byte(24'h000011, 8'hA1);
      push_byte(24'h000012, 8'hA2);
      in_valid = 1'b1;
      in_address = 24'h000040;
      in_data = 8'hB0;
      #1;
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL gap_ready_drop got=%b exp=0", in_ready); end
      serve_burst();
      n_checks++; if (cap_addr !== 24'h000010 || cap_size !== 6'd3)
         begin n_fail++; $display("FAIL gap_burst1 got=%h/%0d exp=000010/3", cap_addr, cap_size); end
      n_checks++; if (cap_data[0] !== 8'hA0 || cap_data[1] !== 8'hA1 || cap_data[2] !== 8'hA2)
         begin n_fail++; $display("FAIL gap_data1 got=%h %h %h exp=a0 a1 a2", cap_data[0], cap_data[1], cap_data[2]); end
      n_checks++; if (cap_rdy_hi !== 1'b0) begin n_fail++; $display("FAIL gap_stall got=%b exp=0", cap_rdy_hi); end
      n_checks++; if (in_ready !== 1'b1)   begin n_fail++; $display("FAIL gap_ready_after_done got=%b exp=1", in_ready); end
      tick();
      in_valid = 1'b0;
      pulse_flush();
      serve_burst();
      n_checks++; if (cap_to !== 1'b0 || cap_addr !== 24'h000040 || cap_size !== 6'd1 || cap_data[0] !== 8'hB0)
         begin n_fail++; $display("FAIL gap_burst2 got=%h/%0d/%h exp=000040/1/b0", cap_addr, cap_size, cap_data[0]); end
   endtask

   task automatic test_page_cross();
      push_byte(24'h0003FE, 8'hC0);
      push_byte(24'h0003FF, 8'hC1);
      in_valid = 1'b1;
      in_address = 24'h000400;
      in_data = 8'hC2;
      #1;
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL page_ready_drop got=%b exp=0", in_ready); end
      serve_burst();
      n_checks++; if (cap_addr !== 24'h0003FE || cap_size !== 6'd2 || cap_data[0] !== 8'hC0 || cap_data[1] !== 8'hC1)
         begin n_fail++; $display("FAIL page_burst1 got=%h/%0d exp=0003fe/2", cap_addr, cap_size); end
      tick();
      in_valid = 1'b0;
      pulse_flush();
      serve_burst();
      n_checks++; if (cap_addr !== 24'h000400 || cap_size !== 6'd1 || cap_data[0] !== 8'hC2)
         begin n_fail++; $display("FAIL page_burst2 got=%h/%0d/%h exp=000400/1/c2", cap_addr, cap_size, cap_data[0]); end
   endtask

   task automatic test_timeout_flush();
      int k = 0;
      for (int i = 0; i < 5; i++) push_byte(24'h002000 + 24'(i), 8'h50 + 8'(i));
      while (!burst_req && k < 100) begin
         tick();
         k++;
      end
      n_checks++; if (k != 64) begin n_fail++; $display("FAIL timeout_cycle got=%0d exp=64", k); end
      serve_burst();
      n_checks++; if (cap_addr !== 24'h002000 || cap_size !== 6'd5 || cap_data[4] !== 8'h54)
         begin n_fail++; $display("FAIL timeout_burst got=%h/%0d/%h exp=002000/5/54", cap_addr, cap_size, cap_data[4]); end
      pulse_flush();
      tick();
      n_checks++; if (burst_req !== 1'b0 || busy !== 1'b0)
         begin n_fail++; $display("FAIL idle_flush req=%b busy=%b exp=0/0", burst_req, busy); end
      for (int i = 0; i < 3; i++) push_byte(24'h003000 + 24'(i), 8'h70 + 8'(i));
      repeat (5) tick();
      pulse_flush();
      n_checks++; if (burst_req !== 1'b1) begin n_fail++; $display("FAIL flush_issue got=%b exp=1", burst_req); end
      serve_burst();
      n_checks++; if (cap_addr !== 24'h003000 || cap_size !== 6'd3 || cap_data[2] !== 8'h72)
         begin n_fail++; $display("FAIL flush_burst got=%h/%0d/%h exp=003000/3/72", cap_addr, cap_size, cap_data[2]); end
   endtask

   task automatic test_reset_mid_stream();
      int seen = 0;
      for (int i = 0; i < 4; i++) push_byte(24'h000500 + 24'(i), 8'h11 * 8'(i + 1));
      pulse_flush();
      burst_ack = 1'b1;
      tick();
      burst_ack = 1'b0;
      next_byte_needed = 1'b1;
      tick();
      tick();
      next_byte_needed = 1'b0;
      #2;
      n_checks++; if (busy !== 1'b1 || burst_data !== 8'h33)
         begin n_fail++; $display("FAIL midstream_pre busy=%b data=%h exp=1/33", busy, burst_data); end
      reset = 1'b0;
      #1;
      n_checks++; if (in_ready !== 1'b0 || burst_req !== 1'b0 || busy !== 1'b0)
         begin n_fail++; $display("FAIL midreset_ctrl rdy=%b req=%b busy=%b exp=0/0/0", in_ready, burst_req, busy); end
      n_checks++; if (burst_address !== 24'h0 || burst_size !== 6'd0 || burst_data !== 8'h0)
         begin n_fail++; $display("FAIL midreset_data addr=%h size=%0d data=%h exp=0/0/0", burst_address, burst_size, burst_data); end
      @(posedge sysclk);
      #1;
      reset = 1'b1;
      for (int i = 0; i < 80; i++) begin
         tick();
         if (burst_req) seen++;
      end
      n_checks++; if (seen != 0)        begin n_fail++; $display("FAIL post_reset_req got=%0d exp=0", seen); end
      n_checks++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL post_reset_busy got=%b exp=0", busy); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready got=%b exp=1", in_ready); end
   endtask

`ifdef PSRAM_COALESCER_STATS_EN
   task automatic test_stats();
      for (int i = 0; i < 4; i++) push_byte(24'h000600 + 24'(i), 8'(i));
      pulse_flush();
      serve_burst();
      for (int i = 0; i < 7; i++) push_byte(24'h000700 + 24'(i), 8'(i));
      pulse_flush();
      serve_burst();
      n_checks++; if (stat_bursts !== 16'd2) begin n_fail++; $display("FAIL stat_bursts got=%0d exp=2", stat_bursts); end
      n_checks++; if (stat_bytes !== 24'd11) begin n_fail++; $display("FAIL stat_bytes got=%0d exp=11", stat_bytes); end
   endtask
`endif

   initial begin
      #2000000;
      $display("FAIL watchdog simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_full_burst();
      test_noncontig();
      test_page_cross();
      test_timeout_flush();
      test_reset_mid_stream();
`ifdef PSRAM_COALESCER_STATS_EN
      test_stats();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/psram_write_coalescer.md
PSRAM_WRITE_COALESCER -- requirements
Module: psram_write_coalescer

Interface
REQ-001 SHALL have parameter MAX_BURST, default 32, meaning the maximum number of bytes per burst (range 1..32).
REQ-002 SHALL have parameter IDLE_TIMEOUT, default 64, meaning the sysclk cycles without new input before a partial burst is issued.
REQ-003 SHALL have port sysclk  in  1  system clock; all logic on posedge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports in_valid (in, 1), in_ready (out, 1), in_address (in, 24) and in_data (in, 8), forming the host byte-write channel.
REQ-006 SHALL have port flush  in  1  single-cycle pulse that forces issue of a pending burst.
REQ-007 SHALL have ports burst_req (out, 1), burst_ack (in, 1), burst_address (out, 24) and burst_size (out, 6), forming the burst request to the PSRAM controller.
REQ-008 SHALL have ports next_byte_needed (in, 1) and burst_data (out, 8), forming the byte stream consumed by the controller.
REQ-009 SHALL have port burst_done  in  1  pulse from the controller when CE is released after the burst.
REQ-010 SHALL have port busy  out  1  high whenever the state is not IDLE or the FIFO holds data.

Function
REQ-011 SHALL accept an input byte on a cycle where in_valid and in_ready are both high.
REQ-012 SHALL hold in_ready high only in IDLE or COLLECT, and only when the FIFO is not full.
REQ-013 SHALL record the first accepted byte's address as burst_address and set count to 1.
REQ-014 SHALL, in COLLECT, accept a byte only if its address equals burst_address+count and does not cross a 1024-byte page (address[9:0] != 0).
REQ-015 SHALL, on a non-contiguous or page-crossing in_valid, drop in_ready the same cycle and move to REQUEST without consuming that byte.
REQ-016 SHALL move from COLLECT to REQUEST on any of: count==MAX_BURST, flush, idle counter reaching IDLE_TIMEOUT, or the REQ-015 condition.
REQ-017 SHALL, when flush arrives in IDLE with an empty FIFO, ignore it.
REQ-018 SHALL drive burst_req high in REQUEST, with burst_address and burst_size stable, until burst_ack is sampled high.
REQ-019 SHALL, on burst_ack, drop burst_req the next cycle and enter STREAM.
REQ-020 SHALL, in STREAM, present the FIFO head on burst_data and pop one byte per cycle that next_byte_needed is high.
REQ-021 SHALL enter WAIT_DONE after the count-th pop.
REQ-022 SHALL, in WAIT_DONE, return to IDLE on burst_done, after which a byte rejected under REQ-015 is accepted normally.
REQ-023 SHALL treat next_byte_needed while the FIFO is empty as a protocol error: hold burst_data and do not pop.
REQ-024 SHALL reset the idle counter on every accepted byte and saturate it at IDLE_TIMEOUT.
REQ-025 SHALL never overflow the FIFO: FIFO depth equals MAX_BURST.

Reset
REQ-026 SHALL, on reset low, immediately clear state to IDLE, FIFO pointers, count and idle counter, even mid-burst.
REQ-027 SHALL reset outputs as follows: in_ready 0, burst_req 0, burst_address 0, burst_size 0, burst_data 0, busy 0.
REQ-028 SHALL raise in_ready on the first clock after reset release.

Configuration
REQ-029 SHALL, with macro PSRAM_COALESCER_STATS_EN defined, add outputs stat_bursts (16) and stat_bytes (24); stat_bursts counts burst_ack handshakes, stat_bytes counts popped bytes, both wrap and both are cleared by reset.
REQ-030 SHALL, without PSRAM_COALESCER_STATS_EN, have neither the ports nor the counter logic.

Structure
REQ-031 SHALL place the state enum (IDLE, COLLECT, REQUEST, STREAM, WAIT_DONE), PAGE_SIZE=1024 and MAX_BURST_LIMIT=32 in shared package psram_pkg.
REQ-032 SHALL implement the byte FIFO as sub-module psram_byte_fifo (parameterised depth, push/pop/full/empty/level).

Verification
REQ-033 SHALL cover: 32 contiguous bytes at 0x000100 -> single burst_req with address 0x000100, size 32; in_ready low from the 33rd cycle until burst_done.
REQ-034 SHALL cover: 3 bytes at 0x10, 0x11, 0x12 then a byte at 0x40 -> burst at 0x10 size 3; the 0x40 byte stalls, then starts a new burst after burst_done.
REQ-035 SHALL cover: bytes at 0x3FE, 0x3FF, 0x400 -> burst at 0x3FE size 2; next burst at 0x400.
REQ-036 SHALL cover: 5 bytes then 64 idle cycles -> burst_req asserted at cycle 64 with size 5; a flush pulse instead issues within 1 cycle.
REQ-037 SHALL cover: reset asserted mid-STREAM -> outputs are zero asynchronously and no burst_req follows release without new input.
REQ-038 SHALL cover: with STATS_EN, two bursts of 4 and 7 bytes -> stat_bursts=2, stat_bytes=11.
